// File: rtl/lsb_queue.sv
// ---------------------------------------------------------------------------
// lsb_queue
//
// Load/store buffer for the out-of-order core. Memory ops are held in program
// order in a circular queue. Each entry picks up its missing operands from the
// result broadcast buses. One access at a time is issued from the head to the
// memory controller.
//
// Ordinary loads run speculatively and broadcast their result. Stores wait
// until the ROB commits them. MMIO loads wait until they reach the ROB head.
// A rollback squashes every uncommitted entry. Committed stores survive the
// rollback and still drain to memory.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   rdy                   global ready; when low every register holds
//   rollback              mispredict flush from the ROB
//   full, free_cnt        occupancy status towards dispatch
//   issue_*               enqueue interface from dispatch
//   mem_*                 single-outstanding request to the memory controller
//   res_valid/res/res_rob_pos   load result broadcast (one-cycle pulse)
//   cdb_valid/val/tag     NUM_CDB result buses, channel k in slice k
//   commit_store, commit_rob_pos  ROB commit of a store
//   rob_head_pos          current ROB head tag (gates MMIO loads)
// ---------------------------------------------------------------------------
module lsb_queue #(
   parameter int         DEPTH   = 16,
   parameter int         ROB_W   = 4,
   parameter int         NUM_CDB = 2,
   parameter logic [1:0] IO_HI   = 2'b11
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       rollback,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     free_cnt,
   input  logic                       issue_en,
   input  logic [ROB_W-1:0]           issue_rob_pos,
   input  logic                       issue_ls,
   input  logic [2:0]                 issue_funct3,
   input  logic                       issue_rs1_rdy,
   input  logic                       issue_rs2_rdy,
   input  logic [31:0]                issue_rs1_val,
   input  logic [31:0]                issue_rs2_val,
   input  logic [ROB_W-1:0]           issue_rs1_tag,
   input  logic [ROB_W-1:0]           issue_rs2_tag,
   input  logic [31:0]                issue_imm,
   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [31:0]                mem_a,
   output logic [2:0]                 mem_l,
   output logic [31:0]                mem_w,
   input  logic                       mem_done,
   input  logic [31:0]                mem_r,
   output logic                       res_valid,
   output logic [31:0]                res,
   output logic [ROB_W-1:0]           res_rob_pos,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [32*NUM_CDB-1:0]      cdb_val,
   input  logic [ROB_W*NUM_CDB-1:0]   cdb_tag,
   input  logic                       commit_store,
   input  logic [ROB_W-1:0]           commit_rob_pos,
   input  logic [ROB_W-1:0]           rob_head_pos
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // Queue bookkeeping
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] commit_cnt;

   // Entry status bits (reset) and payload (not reset, gated by e_valid)
   logic [DEPTH-1:0]             e_valid;
   logic [DEPTH-1:0]             e_committed;
   logic [DEPTH-1:0]             e_ls;
   logic [DEPTH-1:0][2:0]        e_funct3;
   logic [DEPTH-1:0][ROB_W-1:0]  e_rob;
   logic [DEPTH-1:0]             e_rs1_rdy;
   logic [DEPTH-1:0]             e_rs2_rdy;
   logic [DEPTH-1:0][31:0]       e_rs1_val;
   logic [DEPTH-1:0][31:0]       e_rs2_val;
   logic [DEPTH-1:0][ROB_W-1:0]  e_rs1_tag;
   logic [DEPTH-1:0][ROB_W-1:0]  e_rs2_tag;
   logic [DEPTH-1:0][31:0]       e_imm;

   // Attributes of the access currently on the memory port
   logic             inflight_ls;
   logic [2:0]       inflight_funct3;
   logic [ROB_W-1:0] inflight_rob;

   // CDB match results
   logic [DEPTH-1:0]        rs1_hit;
   logic [DEPTH-1:0]        rs2_hit;
   logic [DEPTH-1:0][31:0]  rs1_hit_val;
   logic [DEPTH-1:0][31:0]  rs2_hit_val;
   logic                    in_rs1_hit;
   logic                    in_rs2_hit;
   logic [31:0]             in_rs1_hit_val;
   logic [31:0]             in_rs2_hit_val;

   // Control decode
   logic [31:0]      head_addr;
   logic             head_io;
   logic             head_ops_rdy;
   logic             can_issue;
   logic             issue_go;
   logic             done_busy;
   logic             pop;
   logic             pop_store;
   logic             res_fire;
   logic             enq;
   logic [DEPTH-1:0] commit_hit;
   logic             commit_fire;
   logic [2:0]       head_len;
   logic [31:0]      load_ext;
   logic [PTR_W-1:0] head_n;
   logic [PTR_W-1:0] tail_n;
   logic [CNT_W-1:0] count_n;
   logic [CNT_W-1:0] commit_cnt_n;

   assign full     = (count == CNT_W'(DEPTH));
   assign free_cnt = CNT_W'(DEPTH) - count;

   // Match every waiting operand, plus the operands of the entry being
   // enqueued, against the result buses. The channels are scanned from the
   // highest index down, so the lowest matching channel is written last and
   // wins.
   always_comb begin
      rs1_hit        = '0;
      rs2_hit        = '0;
      rs1_hit_val    = '0;
      rs2_hit_val    = '0;
      in_rs1_hit     = 1'b0;
      in_rs2_hit     = 1'b0;
      in_rs1_hit_val = '0;
      in_rs2_hit_val = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (cdb_valid[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cdb_tag[ROB_W*k +: ROB_W] == e_rs1_tag[i]) begin
                  rs1_hit[i]     = 1'b1;
                  rs1_hit_val[i] = cdb_val[32*k +: 32];
               end
               if (cdb_tag[ROB_W*k +: ROB_W] == e_rs2_tag[i]) begin
                  rs2_hit[i]     = 1'b1;
                  rs2_hit_val[i] = cdb_val[32*k +: 32];
               end
            end
            if (cdb_tag[ROB_W*k +: ROB_W] == issue_rs1_tag) begin
               in_rs1_hit     = 1'b1;
               in_rs1_hit_val = cdb_val[32*k +: 32];
            end
            if (cdb_tag[ROB_W*k +: ROB_W] == issue_rs2_tag) begin
               in_rs2_hit     = 1'b1;
               in_rs2_hit_val = cdb_val[32*k +: 32];
            end
         end
      end
   end

   // Decide whether the head entry may go to memory this cycle and work out
   // the next values of the queue pointers and counters. A commit in the same
   // cycle as a rollback is counted first, so the committed store survives
   // the flush.
   always_comb begin
      head_addr    = e_rs1_val[head] + e_imm[head];
      head_io      = (head_addr[17:16] == IO_HI);
      head_ops_rdy = e_rs1_rdy[head] && (!e_ls[head] || e_rs2_rdy[head]);
      can_issue    = (state == IDLE) && (count != '0) && e_valid[head] &&
                     head_ops_rdy &&
                     (e_ls[head] ? e_committed[head]
                                 : (!head_io || (e_rob[head] == rob_head_pos)));
      // During a rollback only a committed store at the head may still start.
      issue_go     = rdy && can_issue && (!rollback || e_ls[head]);
      done_busy    = rdy && (state == BUSY) && mem_done;
      // A load that completes in the rollback cycle is discarded and not popped.
      pop          = done_busy && (inflight_ls || !rollback);
      pop_store    = pop && inflight_ls;
      res_fire     = done_busy && !inflight_ls && !rollback;
      // Enqueueing into a full queue is accepted only when the head pops in
      // the same cycle.
      enq          = rdy && issue_en && !rollback && (!full || pop);

      for (int i = 0; i < DEPTH; i++) begin
         commit_hit[i] = e_valid[i] && e_ls[i] && !e_committed[i] &&
                         (e_rob[i] == commit_rob_pos);
      end
      commit_fire  = rdy && commit_store && (|commit_hit);

      commit_cnt_n = commit_cnt + CNT_W'(commit_fire) - CNT_W'(pop_store);
      head_n       = head + PTR_W'(pop);
      if (rollback) begin
         count_n = commit_cnt_n;
         tail_n  = head_n + commit_cnt_n[PTR_W-1:0];
      end else begin
         count_n = count + CNT_W'(enq) - CNT_W'(pop);
         tail_n  = tail + PTR_W'(enq);
      end

      case (e_funct3[head][1:0])
         2'b00:   head_len = 3'd1;
         2'b01:   head_len = 3'd2;
         default: head_len = 3'd4;
      endcase

      case (inflight_funct3)
         3'b000:  load_ext = {{24{mem_r[7]}}, mem_r[7:0]};
         3'b001:  load_ext = {{16{mem_r[15]}}, mem_r[15:0]};
         3'b100:  load_ext = {24'd0, mem_r[7:0]};
         3'b101:  load_ext = {16'd0, mem_r[15:0]};
         default: load_ext = mem_r;
      endcase
   end

   // State register for the memory-port FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. BUSY waits for mem_done. If a load is in flight when a
   // rollback arrives, the FSM moves to DRAIN, which waits out the access
   // without producing a result.
   always_comb begin
      next_state = state;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (issue_go) begin
                  next_state = BUSY;
               end
            end
            BUSY: begin
               if (mem_done) begin
                  next_state = IDLE;
               end else if (rollback && !inflight_ls) begin
                  next_state = DRAIN;
               end
            end
            DRAIN: begin
               if (mem_done) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Entry payload: write the enqueued op at tail, including operands
   // bypassed from this cycle's CDBs, and capture broadcasts for waiting
   // operands. Stale payload in invalid slots is harmless.
   always_ff @(posedge clk) begin
      if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!e_rs1_rdy[i] && rs1_hit[i]) begin
               e_rs1_rdy[i] <= 1'b1;
               e_rs1_val[i] <= rs1_hit_val[i];
            end
            if (!e_rs2_rdy[i] && rs2_hit[i]) begin
               e_rs2_rdy[i] <= 1'b1;
               e_rs2_val[i] <= rs2_hit_val[i];
            end
         end
         if (enq) begin
            e_ls[tail]      <= issue_ls;
            e_funct3[tail]  <= issue_funct3;
            e_rob[tail]     <= issue_rob_pos;
            e_imm[tail]     <= issue_imm;
            e_rs1_tag[tail] <= issue_rs1_tag;
            e_rs2_tag[tail] <= issue_rs2_tag;
            e_rs1_rdy[tail] <= issue_rs1_rdy || in_rs1_hit;
            e_rs2_rdy[tail] <= issue_rs2_rdy || in_rs2_hit;
            e_rs1_val[tail] <= issue_rs1_rdy ? issue_rs1_val : in_rs1_hit_val;
            e_rs2_val[tail] <= issue_rs2_rdy ? issue_rs2_val : in_rs2_hit_val;
         end
      end
   end

   // Pointers, entry status bits and the registered memory/result outputs.
   // The update order (commit, rollback squash, pop, enqueue) matters: an
   // enqueue into the slot popped in the same cycle must win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         commit_cnt      <= '0;
         e_valid         <= '0;
         e_committed     <= '0;
         mem_en          <= 1'b0;
         mem_wr          <= 1'b0;
         mem_a           <= '0;
         mem_l           <= '0;
         mem_w           <= '0;
         res_valid       <= 1'b0;
         res             <= '0;
         res_rob_pos     <= '0;
         inflight_ls     <= 1'b0;
         inflight_funct3 <= '0;
         inflight_rob    <= '0;
      end else if (rdy) begin
         head       <= head_n;
         tail       <= tail_n;
         count      <= count_n;
         commit_cnt <= commit_cnt_n;

         for (int i = 0; i < DEPTH; i++) begin
            if (commit_fire && commit_hit[i]) begin
               e_committed[i] <= 1'b1;
            end
            if (rollback && !(e_committed[i] || (commit_fire && commit_hit[i]))) begin
               e_valid[i] <= 1'b0;
            end
         end
         if (pop) begin
            e_valid[head]     <= 1'b0;
            e_committed[head] <= 1'b0;
         end
         if (enq) begin
            e_valid[tail]     <= 1'b1;
            e_committed[tail] <= 1'b0;
         end

         if (issue_go) begin
            mem_en          <= 1'b1;
            mem_wr          <= e_ls[head];
            mem_a           <= head_addr;
            mem_l           <= head_len;
            mem_w           <= e_rs2_val[head];
            inflight_ls     <= e_ls[head];
            inflight_funct3 <= e_funct3[head];
            inflight_rob    <= e_rob[head];
         end else if ((state != IDLE) && mem_done) begin
            mem_en <= 1'b0;
         end

         res_valid <= 1'b0;
         if (res_fire) begin
            res_valid   <= 1'b1;
            res         <= load_ext;
            res_rob_pos <= inflight_rob;
         end
      end
   end

endmodule

// File: tb/tb_lsb_queue.sv
// ---------------------------------------------------------------------------
// tb_lsb_queue
//
// Directed testbench for lsb_queue. Each scenario task drives its own stimulus
// and compares outputs against hand-computed values. Inputs are driven 1 ns
// after the rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_lsb_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        full;
   logic [4:0]  free_cnt;
   logic        issue_en;
   logic [3:0]  issue_rob_pos;
   logic        issue_ls;
   logic [2:0]  issue_funct3;
   logic        issue_rs1_rdy;
   logic        issue_rs2_rdy;
   logic [31:0] issue_rs1_val;
   logic [31:0] issue_rs2_val;
   logic [3:0]  issue_rs1_tag;
   logic [3:0]  issue_rs2_tag;
   logic [31:0] issue_imm;
   logic        mem_en;
   logic        mem_wr;
   logic [31:0] mem_a;
   logic [2:0]  mem_l;
   logic [31:0] mem_w;
   logic        mem_done;
   logic [31:0] mem_r;
   logic        res_valid;
   logic [31:0] res;
   logic [3:0]  res_rob_pos;
   logic [1:0]  cdb_valid;
   logic [63:0] cdb_val;
   logic [7:0]  cdb_tag;
   logic        commit_store;
   logic [3:0]  commit_rob_pos;
   logic [3:0]  rob_head_pos;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsb_queue #(
      .DEPTH   (16),
      .ROB_W   (4),
      .NUM_CDB (2),
      .IO_HI   (2'b11)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rollback       (rollback),
      .full           (full),
      .free_cnt       (free_cnt),
      .issue_en       (issue_en),
      .issue_rob_pos  (issue_rob_pos),
      .issue_ls       (issue_ls),
      .issue_funct3   (issue_funct3),
      .issue_rs1_rdy  (issue_rs1_rdy),
      .issue_rs2_rdy  (issue_rs2_rdy),
      .issue_rs1_val  (issue_rs1_val),
      .issue_rs2_val  (issue_rs2_val),
      .issue_rs1_tag  (issue_rs1_tag),
      .issue_rs2_tag  (issue_rs2_tag),
      .issue_imm      (issue_imm),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_a          (mem_a),
      .mem_l          (mem_l),
      .mem_w          (mem_w),
      .mem_done       (mem_done),
      .mem_r          (mem_r),
      .res_valid      (res_valid),
      .res            (res),
      .res_rob_pos    (res_rob_pos),
      .cdb_valid      (cdb_valid),
      .cdb_val        (cdb_val),
      .cdb_tag        (cdb_tag),
      .commit_store   (commit_store),
      .commit_rob_pos (commit_rob_pos),
      .rob_head_pos   (rob_head_pos)
   );

   // Dispatch must never enqueue into a full queue unless the head pops in
   // the same cycle.
   always @(posedge clk) begin
      if (rst && rdy && issue_en && full && !mem_done) begin
         bad++;
         $display("[TB] FAIL illegal_enqueue_while_full full=%0b mem_done=%0b", full, mem_done);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rdy            = 1'b1;
      rollback       = 1'b0;
      issue_en       = 1'b0;
      issue_rob_pos  = '0;
      issue_ls       = 1'b0;
      issue_funct3   = '0;
      issue_rs1_rdy  = 1'b0;
      issue_rs2_rdy  = 1'b0;
      issue_rs1_val  = '0;
      issue_rs2_val  = '0;
      issue_rs1_tag  = '0;
      issue_rs2_tag  = '0;
      issue_imm      = '0;
      mem_done       = 1'b0;
      mem_r          = '0;
      cdb_valid      = '0;
      cdb_val        = '0;
      cdb_tag        = '0;
      commit_store   = 1'b0;
      commit_rob_pos = '0;
      rob_head_pos   = '0;
   endtask

   task automatic enq(input logic ls, input logic [2:0] f3, input logic [3:0] rob,
                      input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                      input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag,
                      input logic [31:0] imm);
      issue_en      = 1'b1;
      issue_ls      = ls;
      issue_funct3  = f3;
      issue_rob_pos = rob;
      issue_rs1_rdy = r1rdy;
      issue_rs1_val = r1val;
      issue_rs1_tag = r1tag;
      issue_rs2_rdy = r2rdy;
      issue_rs2_val = r2val;
      issue_rs2_tag = r2tag;
      issue_imm     = imm;
      tick();
      issue_en      = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en got=%0b exp=0", mem_en); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid got=%0b exp=0", res_valid); end
      total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%0b exp=0", full); end
      total++; if (free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL reset_free_cnt got=%0d exp=16", free_cnt); end
      total++; if (mem_a !== 32'h0 || mem_l !== 3'd0 || res !== 32'h0) begin bad++; $display("[TB] FAIL reset_regs mem_a=%0h mem_l=%0d res=%0h exp=0", mem_a, mem_l, res); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_load;
      logic [2:0]  f3;
      logic [31:0] base, imm, mr, ea, er;
      logic [2:0]  el;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin f3 = 3'b010; base = 32'h1000; imm = 32'd4;        mr = 32'hDEADBEEF; ea = 32'h1004; el = 3'd4; er = 32'hDEADBEEF; end
            1: begin f3 = 3'b000; base = 32'h2000; imm = 32'd0;        mr = 32'h00000080; ea = 32'h2000; el = 3'd1; er = 32'hFFFFFF80; end
            default: begin f3 = 3'b101; base = 32'h2100; imm = 32'hFFFFFFFE; mr = 32'hFFFF8001; ea = 32'h20FE; el = 3'd2; er = 32'h00008001; end
         endcase
         enq(1'b0, f3, 4'(5 + i), 1'b1, base, 4'd0, 1'b0, 32'h0, 4'd0, imm);
         tick();
         total++; if (mem_en !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("[TB] FAIL load%0d_issue mem_en=%0b mem_wr=%0b exp=1/0", i, mem_en, mem_wr); end
         total++; if (mem_a !== ea || mem_l !== el) begin bad++; $display("[TB] FAIL load%0d_addr mem_a=%0h mem_l=%0d exp=%0h/%0d", i, mem_a, mem_l, ea, el); end
         mem_done = 1'b1;
         mem_r    = mr;
         tick();
         mem_done = 1'b0;
         total++; if (res_valid !== 1'b1 || res !== er) begin bad++; $display("[TB] FAIL load%0d_result res_valid=%0b res=%0h exp=1/%0h", i, res_valid, res, er); end
         total++; if (res_rob_pos !== 4'(5 + i) || mem_en !== 1'b0) begin bad++; $display("[TB] FAIL load%0d_done rob=%0d mem_en=%0b exp=%0d/0", i, res_rob_pos, mem_en, 5 + i); end
         tick();
         total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL load%0d_pulse res_valid=%0b exp=0", i, res_valid); end
      end
      total++; if (free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL load_free_cnt got=%0d exp=16", free_cnt); end
   endtask

   task automatic test_store_cdb;
      enq(1'b1, 3'b010, 4'd6, 1'b1, 32'h2000, 4'd0, 1'b0, 32'h0, 4'd3, 32'd8);
      tick();
      cdb_valid = 2'b11;
      cdb_tag   = {4'd3, 4'd7};
      cdb_val   = {32'h00000055, 32'h00000099};
      tick();
      cdb_valid = 2'b00;
      tick();
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL store_wait_commit mem_en=%0b exp=0", mem_en); end
      commit_store   = 1'b1;
      commit_rob_pos = 4'd6;
      tick();
      commit_store   = 1'b0;
      tick();
      total++; if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin bad++; $display("[TB] FAIL store_issue mem_en=%0b mem_wr=%0b exp=1/1", mem_en, mem_wr); end
      total++; if (mem_w !== 32'h55 || mem_a !== 32'h2008 || mem_l !== 3'd4) begin bad++; $display("[TB] FAIL store_data mem_w=%0h mem_a=%0h mem_l=%0d exp=55/2008/4", mem_w, mem_a, mem_l); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      total++; if (mem_en !== 1'b0 || res_valid !== 1'b0 || free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL store_done mem_en=%0b res_valid=%0b free=%0d exp=0/0/16", mem_en, res_valid, free_cnt); end
   endtask

   task automatic test_bypass;
      // Both channels carry the wanted tag in the enqueue cycle; channel 0 wins.
      cdb_valid = 2'b11;
      cdb_tag   = {4'd4, 4'd4};
      cdb_val   = {32'h00000099, 32'h00000077};
      enq(1'b1, 3'b000, 4'd8, 1'b1, 32'h2200, 4'd0, 1'b0, 32'h0, 4'd4, 32'd0);
      cdb_valid = 2'b00;
      commit_store   = 1'b1;
      commit_rob_pos = 4'd8;
      tick();
      commit_store   = 1'b0;
      tick();
      total++; if (mem_en !== 1'b1 || mem_w !== 32'h77 || mem_l !== 3'd1 || mem_a !== 32'h2200) begin bad++; $display("[TB] FAIL bypass_store mem_en=%0b mem_w=%0h mem_l=%0d mem_a=%0h exp=1/77/1/2200", mem_en, mem_w, mem_l, mem_a); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
   endtask

   task automatic test_mmio;
      rob_head_pos = 4'd2;
      enq(1'b0, 3'b001, 4'd10, 1'b1, 32'h00030000, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      tick();
      tick();
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL mmio_hold mem_en=%0b exp=0", mem_en); end
      rob_head_pos = 4'd10;
      tick();
      total++; if (mem_en !== 1'b1 || mem_a !== 32'h00030000 || mem_l !== 3'd2) begin bad++; $display("[TB] FAIL mmio_issue mem_en=%0b mem_a=%0h mem_l=%0d exp=1/30000/2", mem_en, mem_a, mem_l); end
      mem_done = 1'b1;
      mem_r    = 32'h00008000;
      tick();
      mem_done = 1'b0;
      total++; if (res_valid !== 1'b1 || res !== 32'hFFFF8000 || res_rob_pos !== 4'd10) begin bad++; $display("[TB] FAIL mmio_result res_valid=%0b res=%0h rob=%0d exp=1/ffff8000/10", res_valid, res, res_rob_pos); end
      rob_head_pos = 4'd0;
      tick();
   endtask

   task automatic test_rdy_freeze;
      enq(1'b0, 3'b010, 4'd11, 1'b1, 32'h500, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      rdy = 1'b0;
      tick();
      tick();
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL freeze_no_issue mem_en=%0b exp=0", mem_en); end
      rdy = 1'b1;
      tick();
      total++; if (mem_en !== 1'b1) begin bad++; $display("[TB] FAIL freeze_resume mem_en=%0b exp=1", mem_en); end
      rdy      = 1'b0;
      mem_done = 1'b1;
      mem_r    = 32'h1;
      tick();
      total++; if (mem_en !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL freeze_hold mem_en=%0b res_valid=%0b exp=1/0", mem_en, res_valid); end
      rdy = 1'b1;
      tick();
      mem_done = 1'b0;
      total++; if (res_valid !== 1'b1 || res !== 32'h1 || mem_en !== 1'b0) begin bad++; $display("[TB] FAIL freeze_done res_valid=%0b res=%0h mem_en=%0b exp=1/1/0", res_valid, res, mem_en); end
      tick();
   endtask

   task automatic test_full_wrap;
      enq(1'b0, 3'b010, 4'd1, 1'b1, 32'h100, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      for (int i = 1; i < 16; i++) begin
         enq(1'b0, 3'b010, 4'(i), 1'b0, 32'h0, 4'd15, 1'b0, 32'h0, 4'd0, 32'd0);
      end
      total++; if (full !== 1'b1 || free_cnt !== 5'd0) begin bad++; $display("[TB] FAIL fill_full full=%0b free=%0d exp=1/0", full, free_cnt); end
      total++; if (mem_en !== 1'b1 || mem_a !== 32'h100) begin bad++; $display("[TB] FAIL fill_head_issue mem_en=%0b mem_a=%0h exp=1/100", mem_en, mem_a); end
      mem_done = 1'b1;
      mem_r    = 32'h12345678;
      enq(1'b0, 3'b010, 4'd0, 1'b0, 32'h0, 4'd15, 1'b0, 32'h0, 4'd0, 32'd0);
      mem_done = 1'b0;
      total++; if (full !== 1'b1 || free_cnt !== 5'd0) begin bad++; $display("[TB] FAIL pop_enq_full full=%0b free=%0d exp=1/0", full, free_cnt); end
      total++; if (res_valid !== 1'b1 || res !== 32'h12345678 || res_rob_pos !== 4'd1) begin bad++; $display("[TB] FAIL pop_enq_result res_valid=%0b res=%0h rob=%0d exp=1/12345678/1", res_valid, res, res_rob_pos); end
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      total++; if (full !== 1'b0 || free_cnt !== 5'd16 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_flush full=%0b free=%0d res_valid=%0b exp=0/16/0", full, free_cnt, res_valid); end
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL full_flush_idle mem_en=%0b exp=0", mem_en); end
   endtask

   task automatic test_rollback_store;
      enq(1'b1, 3'b000, 4'd1, 1'b1, 32'h300, 4'd0, 1'b1, 32'hA1, 4'd0, 32'd0);
      enq(1'b1, 3'b000, 4'd2, 1'b1, 32'h300, 4'd0, 1'b1, 32'hB2, 4'd0, 32'd1);
      enq(1'b0, 3'b010, 4'd3, 1'b1, 32'h600, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      enq(1'b0, 3'b010, 4'd4, 1'b1, 32'h604, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      enq(1'b0, 3'b010, 4'd5, 1'b1, 32'h608, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      commit_store   = 1'b1;
      commit_rob_pos = 4'd1;
      tick();
      commit_rob_pos = 4'd2;
      tick();
      commit_store   = 1'b0;
      total++; if (mem_en !== 1'b1 || mem_a !== 32'h300 || mem_w !== 32'hA1 || mem_l !== 3'd1) begin bad++; $display("[TB] FAIL sb1_issue mem_en=%0b mem_a=%0h mem_w=%0h mem_l=%0d exp=1/300/a1/1", mem_en, mem_a, mem_w, mem_l); end
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      total++; if (free_cnt !== 5'd14 || mem_en !== 1'b1) begin bad++; $display("[TB] FAIL rb_keep_stores free=%0d mem_en=%0b exp=14/1", free_cnt, mem_en); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      total++; if (mem_en !== 1'b0 || free_cnt !== 5'd15 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL sb1_done mem_en=%0b free=%0d res_valid=%0b exp=0/15/0", mem_en, free_cnt, res_valid); end
      tick();
      total++; if (mem_en !== 1'b1 || mem_a !== 32'h301 || mem_w !== 32'hB2) begin bad++; $display("[TB] FAIL sb2_issue mem_en=%0b mem_a=%0h mem_w=%0h exp=1/301/b2", mem_en, mem_a, mem_w); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      tick();
      tick();
      total++; if (mem_en !== 1'b0 || free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL rb_loads_squashed mem_en=%0b free=%0d exp=0/16", mem_en, free_cnt); end
   endtask

   task automatic test_rollback_load;
      enq(1'b0, 3'b010, 4'd7, 1'b1, 32'h400, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      tick();
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      tick();
      total++; if (mem_en !== 1'b1 || free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL drain_hold mem_en=%0b free=%0d exp=1/16", mem_en, free_cnt); end
      mem_done = 1'b1;
      mem_r    = 32'hAAAA;
      tick();
      mem_done = 1'b0;
      total++; if (mem_en !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_discard mem_en=%0b res_valid=%0b exp=0/0", mem_en, res_valid); end
      tick();
      total++; if (mem_en !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_idle mem_en=%0b res_valid=%0b exp=0/0", mem_en, res_valid); end
      enq(1'b0, 3'b010, 4'd8, 1'b1, 32'h404, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      tick();
      rollback = 1'b1;
      mem_done = 1'b1;
      tick();
      rollback = 1'b0;
      mem_done = 1'b0;
      total++; if (mem_en !== 1'b0 || res_valid !== 1'b0 || free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL rb_same_cycle_load mem_en=%0b res_valid=%0b free=%0d exp=0/0/16", mem_en, res_valid, free_cnt); end
      tick();
      total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL rb_same_cycle_reissue mem_en=%0b exp=0", mem_en); end
   endtask

   task automatic test_async_reset;
      enq(1'b0, 3'b010, 4'd1, 1'b1, 32'h700, 4'd0, 1'b0, 32'h0, 4'd0, 32'd0);
      enq(1'b0, 3'b010, 4'd2, 1'b0, 32'h0, 4'd15, 1'b0, 32'h0, 4'd0, 32'd0);
      total++; if (mem_en !== 1'b1 || free_cnt !== 5'd14) begin bad++; $display("[TB] FAIL pre_reset_busy mem_en=%0b free=%0d exp=1/14", mem_en, free_cnt); end
      #2;
      rst = 1'b0;
      #1;
      total++; if (mem_en !== 1'b0 || full !== 1'b0 || free_cnt !== 5'd16) begin bad++; $display("[TB] FAIL async_reset mem_en=%0b full=%0b free=%0d exp=0/0/16", mem_en, full, free_cnt); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      $display("[TB] starting lsb_queue bench");
      test_reset();
      test_load();
      test_store_cdb();
      test_bypass();
      test_mmio();
      test_rdy_freeze();
      test_full_wrap();
      test_rollback_store();
      test_rollback_load();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
